// File: rtl/serve_ctrl_pkg.sv
// Shared Pong serve definitions: FSM state encoding and serve speed decode.
package serve_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    COUNTDOWN,
    LAUNCH,
    PLAY
  } state_e;

  localparam logic [1:0] SPEED_MIN = 2'd1;

  // A zero vertical speed would give a flat serve, so it is promoted to the minimum.
  function automatic logic [1:0] decode_speed(input logic [1:0] raw);
    return (raw == 2'd0) ? SPEED_MIN : raw;
  endfunction

endpackage

// File: rtl/serve_shift_collect.sv
// Gathers RAND_BITS random bits MSB-first into a shift register; done pulses on the last bit.
module serve_shift_collect #(
  parameter int RAND_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 rand_bit,
  output logic [RAND_BITS-1:0] vec_q,
  output logic [RAND_BITS-1:0] vec_d,
  output logic                 done
);

  localparam int CW = $clog2(RAND_BITS + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    vec_d = vec_q;
    cnt_d = cnt_q;
    done  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      vec_d = {vec_q[RAND_BITS-2:0], rand_bit};
      done  = (cnt_q == CW'(RAND_BITS - 1));
      cnt_d = done ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q <= '0;
      cnt_q <= '0;
    end else begin
      vec_q <= vec_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serve_ctrl.sv
// Pong serve controller: holds the ball, collects random serve bits, counts frame ticks, launches.
module serve_ctrl
  import serve_ctrl_pkg::*;
#(
  parameter int RAND_BITS   = 4,
  parameter int DELAY_TICKS = 60,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rand_bit,
  input  logic             serve_req,
  input  logic             tick,
  input  logic             ball_out,
  output logic             ball_hold,
  output logic             serve_valid,
  output logic             dir_x,
  output logic             dir_y,
  output logic [1:0]       speed_y,
  output logic [CNT_W-1:0] serve_cnt,
  output logic             busy
);

  localparam int TCNT_W = $clog2(DELAY_TICKS + 2);

  state_e                 state_q, state_d;
  logic [TCNT_W-1:0]      tcnt_q, tcnt_d;
  logic                   hold_q, hold_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   dir_x_q, dir_x_d;
  logic                   dir_y_q, dir_y_d;
  logic [1:0]             speed_q, speed_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   col_clear, col_en, col_done, launch;
  logic [RAND_BITS-1:0]   vec_q, vec_d, launch_vec;

  assign col_clear = (state_q == IDLE) && serve_req;
  assign col_en    = (state_q == COLLECT);

  serve_shift_collect #(
    .RAND_BITS(RAND_BITS)
  ) u_collect (
    .clk     (clk),
    .rst     (rst),
    .clear   (col_clear),
    .en      (col_en),
    .rand_bit(rand_bit),
    .vec_q   (vec_q),
    .vec_d   (vec_d),
    .done    (col_done)
  );

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    launch     = 1'b0;
    launch_vec = vec_q;
    dir_x_d    = dir_x_q;
    dir_y_d    = dir_y_q;
    speed_d    = speed_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (serve_req) state_d = COLLECT;
      end
      COLLECT: begin
        if (col_done) begin
          tcnt_d = '0;
          if (DELAY_TICKS == 0) begin
            // Last bit is still in flight, so decode from the shift register's next value.
            state_d    = LAUNCH;
            launch     = 1'b1;
            launch_vec = vec_d;
          end else begin
            state_d = COUNTDOWN;
          end
        end
      end
      COUNTDOWN: begin
        if (tick) begin
          tcnt_d = tcnt_q + 1'b1;
          if (tcnt_d == TCNT_W'(DELAY_TICKS)) begin
            state_d = LAUNCH;
            launch  = 1'b1;
          end
        end
      end
      LAUNCH: state_d = PLAY;
      PLAY: begin
        if (ball_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      dir_x_d = launch_vec[0];
      dir_y_d = launch_vec[1];
      speed_d = decode_speed(launch_vec[3:2]);
      cnt_d   = cnt_q + 1'b1;
    end

    hold_d  = (state_d == IDLE) || (state_d == COLLECT) || (state_d == COUNTDOWN);
    valid_d = (state_d == LAUNCH);
    busy_d  = (state_d == COLLECT) || (state_d == COUNTDOWN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      hold_q  <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      dir_x_q <= 1'b0;
      dir_y_q <= 1'b0;
      speed_q <= SPEED_MIN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      speed_q <= speed_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ball_hold   = hold_q;
  assign serve_valid = valid_q;
  assign busy        = busy_q;
  assign dir_x       = dir_x_q;
  assign dir_y       = dir_y_q;
  assign speed_y     = speed_q;
  assign serve_cnt   = cnt_q;

endmodule

// File: tb/tb_serve_ctrl.sv
// Bench for serve_ctrl: instance 0 has no countdown and a 2-bit counter, instance 1 waits 3 ticks.
module tb_serve_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v[2], bit_v[2], req_v[2], tick_v[2], out_v[2];
  logic       hold_o[2], valid_o[2], dirx_o[2], diry_o[2], busy_o[2];
  logic [1:0] spd_o[2];
  logic [1:0] cnt_a;
  logic [7:0] cnt_b;

  int total = 0;
  int bad   = 0;
  int exp_cnt[2], exp_dx[2], exp_dy[2], exp_sp[2];

  serve_ctrl #(.RAND_BITS(4), .DELAY_TICKS(0), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst_v[0]), .rand_bit(bit_v[0]), .serve_req(req_v[0]),
    .tick(tick_v[0]), .ball_out(out_v[0]), .ball_hold(hold_o[0]),
    .serve_valid(valid_o[0]), .dir_x(dirx_o[0]), .dir_y(diry_o[0]),
    .speed_y(spd_o[0]), .serve_cnt(cnt_a), .busy(busy_o[0])
  );

  serve_ctrl #(.RAND_BITS(4), .DELAY_TICKS(3), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst_v[1]), .rand_bit(bit_v[1]), .serve_req(req_v[1]),
    .tick(tick_v[1]), .ball_out(out_v[1]), .ball_hold(hold_o[1]),
    .serve_valid(valid_o[1]), .dir_x(dirx_o[1]), .dir_y(diry_o[1]),
    .speed_y(spd_o[1]), .serve_cnt(cnt_b), .busy(busy_o[1])
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cnt_of(input int d);
    return (d == 1) ? int'(cnt_b) : int'(cnt_a);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int d);
    bit_v[d] = 1'b0; req_v[d] = 1'b0; tick_v[d] = 1'b0; out_v[d] = 1'b0;
  endtask

  task automatic chk_held(input int d, input string tag);
    chk({tag, "_hold"},  hold_o[d],  1);
    chk({tag, "_valid"}, valid_o[d], 0);
    chk({tag, "_dx"},    dirx_o[d],  exp_dx[d]);
    chk({tag, "_dy"},    diry_o[d],  exp_dy[d]);
    chk({tag, "_spd"},   spd_o[d],   exp_sp[d]);
    chk({tag, "_cnt"},   cnt_of(d),  exp_cnt[d]);
  endtask

  // One full serve from IDLE; with abort set, reset hits right after the first countdown tick.
  task automatic run_serve(input int d, input logic [3:0] v, input bit abort);
    int ticks, guard;
    bit t;
    chk_held(d, "idle_pre");
    chk("idle_pre_busy", busy_o[d], 0);
    req_v[d] = 1'b1; bit_v[d] = 1'($urandom); tick_v[d] = 1'($urandom);
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk_held(d, "collect");
      chk("collect_busy", busy_o[d], 1);
      bit_v[d] = v[3-i]; tick_v[d] = 1'($urandom);
      out_v[d] = 1'($urandom); req_v[d] = 1'($urandom);
      cyc();
    end
    quiet(d);
    if (d == 1) begin
      ticks = 0; guard = 0;
      while (ticks < 3 && guard < 300) begin
        chk_held(d, "countdown");
        chk("countdown_busy", busy_o[d], 1);
        t = ($urandom_range(0, 3) == 0);
        tick_v[d] = t; req_v[d] = 1'($urandom); out_v[d] = 1'($urandom);
        bit_v[d] = 1'($urandom);
        cyc();
        guard++;
        if (t) ticks++;
        if (abort && t && ticks == 1) begin
          quiet(d);
          chk("abort_busy", busy_o[d], 1);
          rst_v[d] = 1'b1;
          cyc();
          rst_v[d] = 1'b0;
          exp_cnt[d] = 0; exp_dx[d] = 0; exp_dy[d] = 0; exp_sp[d] = 1;
          chk_held(d, "abort");
          chk("abort_busy_after", busy_o[d], 0);
          cyc();
          chk_held(d, "abort_next");
          return;
        end
      end
      if (guard >= 300) chk("countdown_timeout", ticks, 3);
      quiet(d);
    end
    exp_dx[d]  = int'(v[0]);
    exp_dy[d]  = int'(v[1]);
    exp_sp[d]  = (v[3:2] == 2'd0) ? 1 : int'(v[3:2]);
    exp_cnt[d] = (exp_cnt[d] + 1) % ((d == 1) ? 256 : 4);
    chk("launch_valid", valid_o[d], 1);
    chk("launch_hold",  hold_o[d],  0);
    chk("launch_busy",  busy_o[d],  0);
    chk("launch_dx",    dirx_o[d],  exp_dx[d]);
    chk("launch_dy",    diry_o[d],  exp_dy[d]);
    chk("launch_spd",   spd_o[d],   exp_sp[d]);
    chk("launch_cnt",   cnt_of(d),  exp_cnt[d]);
    req_v[d] = 1'($urandom); out_v[d] = 1'($urandom);
    cyc();
    req_v[d] = 1'b0; out_v[d] = 1'b0;
    for (int i = 0; i < int'($urandom_range(1, 5)); i++) begin
      chk("play_hold",  hold_o[d],  0);
      chk("play_valid", valid_o[d], 0);
      chk("play_busy",  busy_o[d],  0);
      chk("play_spd",   spd_o[d],   exp_sp[d]);
      chk("play_cnt",   cnt_of(d),  exp_cnt[d]);
      req_v[d] = 1'($urandom);
      cyc();
    end
    chk("play_end_hold", hold_o[d], 0);
    req_v[d] = 1'b1; out_v[d] = 1'b1;
    cyc();
    quiet(d);
    chk_held(d, "point");
    chk("point_busy", busy_o[d], 0);
    cyc();
    chk("point_next_busy", busy_o[d], 0);
    chk("point_next_hold", hold_o[d], 1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      quiet(d);
      rst_v[d] = 1'b1;
      exp_cnt[d] = 0; exp_dx[d] = 0; exp_dy[d] = 0; exp_sp[d] = 1;
    end
    repeat (3) cyc();
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      for (int d = 0; d < 2; d++) begin
        chk_held(d, "reset");
        chk("reset_busy", busy_o[d], 0);
        bit_v[d] = 1'($urandom); tick_v[d] = 1'($urandom); out_v[d] = 1'($urandom);
      end
      cyc();
    end
    quiet(0); quiet(1);
    cyc();

    run_serve(0, 4'b1011, 1'b0);
    for (int r = 0; r < 5; r++) run_serve(0, 4'($urandom), 1'b0);

    run_serve(1, 4'($urandom), 1'b1);
    run_serve(1, 4'b0000, 1'b0);
    for (int r = 0; r < 4; r++) run_serve(1, 4'($urandom), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
